// File: rtl/high_radix_multiplication_pkg.sv
// Shared definitions for the iterative radix-4 unsigned multiplier.
//   DEFAULT_WIDTH : default operand width (product is twice this)
//   RADIX_BITS    : multiplier bits retired per iteration (radix 4)
//   NUM_DIGITS    : iterations needed for a DEFAULT_WIDTH multiplier
//   state_t       : controller states LOAD / RUN / DONE
package high_radix_multiplication_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int RADIX_BITS    = 2;
    localparam int NUM_DIGITS    = DEFAULT_WIDTH / RADIX_BITS;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/high_radix_pp_select.sv
// Radix-4 partial product selector (purely combinational).
// Ports:
//   a     : multiplicand A
//   a3    : precomputed 3*A (two bits wider than A)
//   digit : current 2-bit multiplier digit
//   pp    : selected partial product 0 / A / 2A / 3A
module high_radix_pp_select #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH+1:0] a3,
    input  logic [1:0]       digit,
    output logic [WIDTH+1:0] pp
);

    always_comb begin
        pp = '0;
        case (digit)
            2'd0:    pp = '0;
            2'd1:    pp = (WIDTH + 2)'(a);
            2'd2:    pp = (WIDTH + 2)'(a) << 1;
            default: pp = a3;
        endcase
    end

endmodule

// File: rtl/high_radix_multiplication.sv
// Iterative radix-4 unsigned multiplier: out = x * y.
// One LOAD cycle captures the operands, then WIDTH/2 RUN cycles each add one
// shifted partial product to the accumulator; the finished sum is copied to
// out, which otherwise holds the last completed product. A change on x or y
// (in RUN or DONE) restarts the computation from LOAD.
// Ports:
//   clk   : clock, rising edge active
//   reset : asynchronous active-high reset
//   x     : unsigned multiplicand
//   y     : unsigned multiplier
//   out   : registered 2*WIDTH-bit product
module high_radix_multiplication
    import high_radix_multiplication_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    output logic [2*WIDTH-1:0]   out
);

    localparam int DIGITS = WIDTH / RADIX_BITS;
    localparam int CNT_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(DIGITS - 1);

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [WIDTH+1:0]     a3;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;

    logic [1:0]           digit;
    logic [WIDTH+1:0]     pp;
    logic [2*WIDTH-1:0]   pp_shifted;
    logic [2*WIDTH-1:0]   acc_sum;
    logic                 ops_changed;
    logic                 finish_now;

    // Digit i of the captured multiplier, bits [2i+1:2i].
    assign digit = b[RADIX_BITS*cnt +: RADIX_BITS];

    high_radix_pp_select #(.WIDTH(WIDTH)) u_pp_select (
        .a     (a),
        .a3    (a3),
        .digit (digit),
        .pp    (pp)
    );

    // Widen before shifting so the top digit's 3A term is never truncated.
    assign pp_shifted = (2*WIDTH)'(pp) << (RADIX_BITS*cnt);
    assign acc_sum    = acc + pp_shifted;

    assign ops_changed = (x != a) || (y != b);

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        finish_now = 1'b0;
        case (state)
            LOAD: begin
                state_next = RUN;
            end
            RUN: begin
                // An operand change wins over completion so an aborted
                // result can never be published.
                if (ops_changed) begin
                    state_next = LOAD;
                end else if (cnt == LAST_DIGIT) begin
                    state_next = DONE;
                    finish_now = 1'b1;
                end
            end
            DONE: begin
                if (ops_changed) begin
                    state_next = LOAD;
                end
            end
            default: begin
                state_next = LOAD;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand registers, counter, accumulator, output register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a   <= '0;
            b   <= '0;
            a3  <= '0;
            acc <= '0;
            cnt <= '0;
            out <= '0;
        end else begin
            case (state)
                LOAD: begin
                    a   <= x;
                    b   <= y;
                    a3  <= (WIDTH + 2)'(x) + ((WIDTH + 2)'(x) << 1);
                    acc <= '0;
                    cnt <= '0;
                end
                RUN: begin
                    acc <= acc_sum;
                    cnt <= cnt + 1'b1;
                    if (finish_now) begin
                        out <= acc_sum;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_high_radix_multiplication.sv
module tb_high_radix_multiplication;

    localparam int W  = 16;
    localparam int PW = 2 * W;

    logic          clk;
    logic          reset;
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic [PW-1:0] out;

    int n_compared;
    int n_mismatched;

    high_radix_multiplication #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y),
        .out   (out)
    );

    // ------------------------------------------------------------------
    // Clock
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: plain unsigned product
    // ------------------------------------------------------------------
    function automatic logic [PW-1:0] ref_product(input logic [W-1:0] xv, input logic [W-1:0] yv);
        logic [PW-1:0] xe;
        logic [PW-1:0] ye;
        xe = PW'(xv);
        ye = PW'(yv);
        return xe * ye;
    endfunction

    // ------------------------------------------------------------------
    // Checker
    // ------------------------------------------------------------------
    task automatic check(input string tag, input logic [PW-1:0] got, input logic [PW-1:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Drivers (called at a falling edge; inputs change there, outputs are
    // sampled at falling edges)
    // ------------------------------------------------------------------

    // Release reset with operands applied: out stays 0 for 8 edges and
    // shows the product on the 9th edge after release.
    task automatic release_and_expect(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv);
        x = xv;
        y = yv;
        reset = 1'b0;
        for (int j = 1; j <= 9; j++) begin
            @(negedge clk);
            if (j < 9) check({tag, "_hold0"}, out, '0);
            else       check({tag, "_prod"}, out, ref_product(xv, yv));
        end
    endtask

    // Apply a new pair while the multiplier is idle: the old product must
    // stay for 9 edges and the new one must appear on the 10th.
    task automatic hold_pair(input string tag, input logic [W-1:0] xv, input logic [W-1:0] yv,
                             input logic [PW-1:0] old_prod);
        x = xv;
        y = yv;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            if (j < 10) check({tag, "_old"}, out, old_prod);
            else        check({tag, "_new"}, out, ref_product(xv, yv));
        end
    endtask

    // Start one pair, interrupt it after k edges with another pair; the
    // interrupted product must never appear.
    task automatic abort_pair(input string tag, input logic [W-1:0] x1, input logic [W-1:0] y1,
                              input int k, input logic [W-1:0] x2, input logic [W-1:0] y2,
                              input logic [PW-1:0] old_prod);
        x = x1;
        y = y1;
        for (int j = 1; j <= k; j++) begin
            @(negedge clk);
            check({tag, "_pre"}, out, old_prod);
        end
        hold_pair(tag, x2, y2, old_prod);
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    logic [W-1:0]  seq_x [5];
    logic [W-1:0]  seq_y [5];
    logic [PW-1:0] seq_p [5];
    logic [PW-1:0] last_prod;

    initial begin
        n_compared   = 0;
        n_mismatched = 0;

        // Reset with unknown operands
        reset = 1'b1;
        x = 'x;
        y = 'x;
        #1;
        check("reset_async", out, '0);
        repeat (2) @(negedge clk);
        check("reset_held", out, '0);

        // 255*255 after a 2-cycle reset
        release_and_expect("r255", 16'd255, 16'd255);
        repeat (2) @(negedge clk);
        check("r255_stable", out, 32'd65025);

        // Reset pulse, 128*128, then y=0, then y=1
        reset = 1'b1;
        @(negedge clk);
        check("rst2", out, '0);
        release_and_expect("r128", 16'd128, 16'd128);
        hold_pair("y0", 16'd128, 16'd0, 32'd16384);
        hold_pair("y1", 16'd128, 16'd1, 32'd0);

        // Fixed sequence with independently stated results
        seq_x = '{16'd25, 16'd64, 16'd36, 16'd11, 16'd80};
        seq_y = '{16'd5,  16'd64, 16'd36, 16'd33, 16'd10};
        seq_p = '{32'd125, 32'd4096, 32'd1296, 32'd363, 32'd800};
        last_prod = 32'd128;
        for (int i = 0; i < 5; i++) begin
            hold_pair("seq", seq_x[i], seq_y[i], last_prod);
            check("seq_table", out, seq_p[i]);
            last_prod = seq_p[i];
        end

        // Maximum operands
        hold_pair("max", 16'hFFFF, 16'hFFFF, last_prod);
        check("max_value", out, 32'hFFFE0001);

        // Restart, then change y in the 4th RUN cycle
        abort_pair("abort", 16'h1234, 16'hFFFF, 5, 16'h1234, 16'h0F0F, 32'hFFFE0001);
        last_prod = ref_product(16'h1234, 16'h0F0F);

        // Reset in the 5th RUN cycle
        x = 16'h00FF;
        y = 16'h0101;
        repeat (6) @(negedge clk);
        check("rst_mid_pre", out, last_prod);
        reset = 1'b1;
        #1;
        check("rst_mid_now", out, '0);
        @(negedge clk);
        check("rst_mid_held", out, '0);
        release_and_expect("rst_mid", 16'h00FF, 16'h0101);
        last_prod = ref_product(16'h00FF, 16'h0101);

        // Zero operands go through the normal path
        hold_pair("x0", 16'd0, 16'hABCD, last_prod);
        last_prod = '0;

        // Random pairs
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] rx;
            logic [W-1:0] ry;
            rx = W'($urandom_range(0, 16'hFFFF));
            ry = W'($urandom_range(0, 16'hFFFF));
            if (i % 5 == 0) rx = 16'hFFFF;
            hold_pair("rand", rx, ry, last_prod);
            last_prod = ref_product(rx, ry);
        end

        // Random aborts at random points of the run
        for (int i = 0; i < 6; i++) begin
            logic [W-1:0] ax;
            logic [W-1:0] ay;
            logic [W-1:0] bx;
            logic [W-1:0] by;
            int k;
            ax = W'($urandom_range(0, 16'hFFFF));
            ay = W'($urandom_range(0, 16'hFFFF));
            bx = W'($urandom_range(0, 16'hFFFF));
            by = W'($urandom_range(0, 16'hFFFF));
            if (bx == ax && by == ay) by = by ^ 16'd1;
            k = $urandom_range(2, 9);
            abort_pair("rabort", ax, ay, k, bx, by, last_prod);
            last_prod = ref_product(bx, by);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/high_radix_multiplication.md
HIGH_RADIX_MULTIPLICATION -- requirements
Module: high_radix_multiplication

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width; product width is 2*WIDTH.
REQ-002 SHALL have port clk, input, 1 bit, single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit; reset is asynchronous and active-high.
REQ-004 SHALL have port x, input, WIDTH bits, unsigned multiplicand.
REQ-005 SHALL have port y, input, WIDTH bits, unsigned multiplier.
REQ-006 SHALL have port out, output, 2*WIDTH bits, registered product x*y.
REQ-007 SHALL use port order clk, reset, x, y, out to support positional instantiation.

Function
REQ-008 SHALL compute an unsigned product using an iterative radix-4 algorithm that retires 2 multiplier bits per cycle, taking WIDTH/2 = 8 iterations.
REQ-009 SHALL implement a three-state FSM: LOAD, RUN, DONE.
REQ-010 In LOAD (one cycle), SHALL capture x→A and y→B, precompute 3A, clear the accumulator and set the digit counter to 0, then go to RUN.
REQ-011 In each RUN cycle, SHALL select the partial product from digit d = B[2i+1:2i] as 0, A, 2A or 3A, and add it to the accumulator.
REQ-012 The RUN partial product SHALL be shifted left by 2i and added in full 2*WIDTH width, with no truncation.
REQ-013 After the 8th RUN cycle, SHALL load out with the accumulator and go to DONE.
REQ-014 Latency SHALL be 9 rising edges from the LOAD edge to out being updated, fitting within a 10-cycle operand hold.
REQ-015 out SHALL hold the last completed product during LOAD and RUN; it SHALL NOT show intermediate values.
REQ-016 In DONE, SHALL compare x,y with the captured A,B every cycle, go to LOAD on any difference, and otherwise stay in DONE.
REQ-017 If x or y changes during RUN, SHALL abort the computation and go to LOAD on the next edge; the aborted result SHALL never reach out.
REQ-018 A zero operand SHALL produce out = 0 via the normal 8-iteration path, with no early-termination shortcut.
REQ-019 The maximum operands 0xFFFF*0xFFFF SHALL give 0xFFFE0001 with no overflow.

Reset
REQ-020 While reset is high, SHALL force out = 0, accumulator = 0, A = B = 0, counter = 0 and state = LOAD, independent of clk.
REQ-021 On the first rising edge after reset deasserts, SHALL perform LOAD with the current x,y.
REQ-022 Reset asserted mid-RUN SHALL discard the computation immediately; out SHALL read 0 until the next completion.
REQ-023 Unknown x,y values while reset is high SHALL NOT propagate to out.

Structure
REQ-024 A shared package SHALL hold the WIDTH default (16), RADIX_BITS = 2, NUM_DIGITS = WIDTH/RADIX_BITS, and the state enum {LOAD, RUN, DONE}.
REQ-025 SHALL use one combinational sub-module, high_radix_pp_select: inputs A, 3A and 2-bit digit; output the selected partial product 0/A/2A/3A.
REQ-026 The top level SHALL contain the FSM, operand registers, change comparator, counter, shifter/accumulator and output register.

Verification
REQ-027 Reset for 2 cycles, then x=255,y=255 held 10 cycles -> out = 65025 by the 10th edge and held stable.
REQ-028 Reset pulse, then x=128,y=128 -> out goes 0 to 16384; change to y=0 without reset -> out = 0 within 10 cycles; then y=1 -> 128.
REQ-029 Sequence without reset, each pair held 10 cycles: (25,5),(64,64),(36,36),(11,33),(80,10) -> out = 125, 4096, 1296, 363, 800 respectively.
REQ-030 x=0xFFFF,y=0xFFFF -> out = 0xFFFE0001; change y at RUN cycle 4 -> no intermediate value appears and the new product arrives 9 edges after restart.
REQ-031 Assert reset at RUN cycle 5 -> out = 0 immediately; after release, the product of current inputs appears 9 edges after the first post-reset edge.
